// File: rtl/radar_sync_gen.sv
// rtl/radar_sync_gen.sv - stand-alone radar trigger/ACP/ARP timing generator
module radar_sync_gen #(
  parameter int PRI_CYC      = 50000,
  parameter int STAGGER_CYC  = 2500,
  parameter int TRIG_W       = 50,
  parameter int TRIG_PER_ACP = 4,
  parameter int ACP_PER_ARP  = 4096,
  parameter int ACP_W        = 25,
  parameter int ARP_W        = 25,
  parameter int RANGE_W      = 16,
  localparam int AZ_W        = $clog2(ACP_PER_ARP)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               stagger,
  output logic               trig,
  output logic               acp,
  output logic               arp,
  output logic               sweep_start,
  output logic [RANGE_W-1:0] range_cnt,
  output logic [AZ_W-1:0]    azimuth
);

  localparam int PRI_W  = $clog2(PRI_CYC + STAGGER_CYC + 1);
  localparam int TIDX_W = (TRIG_PER_ACP > 1) ? $clog2(TRIG_PER_ACP) : 1;
  localparam int TW_W   = $clog2(TRIG_W + 1);
  localparam int AW_W   = $clog2(ACP_W + 1);
  localparam int RW_W   = $clog2(ARP_W + 1);

  localparam logic [PRI_W-1:0]   PRI_BASE  = PRI_W'(PRI_CYC);
  localparam logic [PRI_W-1:0]   PRI_STAG  = PRI_W'(PRI_CYC + STAGGER_CYC);
  localparam logic [TIDX_W-1:0]  TIDX_LAST = TIDX_W'(TRIG_PER_ACP - 1);
  localparam logic [AZ_W-1:0]    AZ_LAST   = AZ_W'(ACP_PER_ARP - 1);
  localparam logic [TW_W-1:0]    TRIG_LOAD = TW_W'(TRIG_W - 1);
  localparam logic [AW_W-1:0]    ACP_LOAD  = AW_W'(ACP_W - 1);
  localparam logic [RW_W-1:0]    ARP_LOAD  = RW_W'(ARP_W - 1);
  localparam logic [RANGE_W-1:0] RANGE_MAX = '1;

  logic [PRI_W-1:0]  pri_cnt;
  logic [PRI_W-1:0]  pri_len;
  logic              tog;
  logic [TIDX_W-1:0] tidx;
  logic [TW_W-1:0]   trig_cnt;
  logic [AW_W-1:0]   acp_cnt;
  logic [RW_W-1:0]   arp_cnt;

  logic trig_evt;
  logic acp_evt;
  logic arp_evt;

  // pri_cnt==0 on an enabled cycle is the trigger; the very first one follows reset
  assign trig_evt = en && (pri_cnt == '0);
  assign acp_evt  = trig_evt && (tidx == TIDX_LAST);
  assign arp_evt  = acp_evt && (azimuth == AZ_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_cnt     <= '0;
      pri_len     <= PRI_BASE;
      tog         <= 1'b0;
      tidx        <= '0;
      azimuth     <= '0;
      range_cnt   <= '0;
      trig        <= 1'b0;
      acp         <= 1'b0;
      arp         <= 1'b0;
      sweep_start <= 1'b0;
      trig_cnt    <= '0;
      acp_cnt     <= '0;
      arp_cnt     <= '0;
    end else if (!en) begin
      // pulses are dropped, not paused; counters keep their place
      trig        <= 1'b0;
      acp         <= 1'b0;
      arp         <= 1'b0;
      sweep_start <= 1'b0;
      trig_cnt    <= '0;
      acp_cnt     <= '0;
      arp_cnt     <= '0;
    end else begin
      sweep_start <= trig_evt;
      pri_cnt     <= (pri_cnt == pri_len - 1'b1) ? '0 : pri_cnt + 1'b1;

      if (!stagger)
        tog <= 1'b0;
      else if (trig_evt)
        tog <= ~tog;

      if (trig_evt) begin
        pri_len   <= (stagger && tog) ? PRI_STAG : PRI_BASE;
        range_cnt <= '0;
        tidx      <= (tidx == TIDX_LAST) ? '0 : tidx + 1'b1;
      end else if (range_cnt != RANGE_MAX) begin
        range_cnt <= range_cnt + 1'b1;
      end

      if (acp_evt)
        azimuth <= azimuth + 1'b1;

      if (trig_evt) begin
        trig     <= 1'b1;
        trig_cnt <= TRIG_LOAD;
      end else if (trig) begin
        if (trig_cnt == '0) trig <= 1'b0;
        else                trig_cnt <= trig_cnt - 1'b1;
      end

      if (acp_evt) begin
        acp     <= 1'b1;
        acp_cnt <= ACP_LOAD;
      end else if (acp) begin
        if (acp_cnt == '0) acp <= 1'b0;
        else               acp_cnt <= acp_cnt - 1'b1;
      end

      if (arp_evt) begin
        arp     <= 1'b1;
        arp_cnt <= ARP_LOAD;
      end else if (arp) begin
        if (arp_cnt == '0) arp <= 1'b0;
        else               arp_cnt <= arp_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_radar_sync_gen.sv
// tb/tb_radar_sync_gen.sv - scoreboard bench for radar_sync_gen
module tb_radar_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       stagger = 1'b0;
  logic       trig, acp, arp, sweep_start;
  logic [3:0] range_cnt;
  logic [1:0] azimuth;

  always #5 clk = ~clk;

  radar_sync_gen #(
    .PRI_CYC(20), .STAGGER_CYC(5), .TRIG_W(3), .TRIG_PER_ACP(2),
    .ACP_PER_ARP(4), .ACP_W(2), .ARP_W(4), .RANGE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .stagger(stagger),
    .trig(trig), .acp(acp), .arp(arp), .sweep_start(sweep_start),
    .range_cnt(range_cnt), .azimuth(azimuth)
  );

  typedef struct {
    int gap;
    int acp;
    int arp;
    int az;
    int rprev;
  } trig_exp_t;

  trig_exp_t exp_q[$];
  int trig_w_q[$];
  int acp_w_q[$];
  int arp_w_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_t(input int gap, input int a, input int r, input int az,
                        input int rp, input int tw, input int aw, input int rw);
    trig_exp_t t;
    t.gap = gap; t.acp = a; t.arp = r; t.az = az; t.rprev = rp;
    exp_q.push_back(t);
    trig_w_q.push_back(tw);
    if (a != 0) acp_w_q.push_back(aw);
    if (r != 0) arp_w_q.push_back(rw);
  endtask

  // monitor: gap is counted in clock edges from the previous trigger or last reset edge
  int cyc = 0;
  int last_cyc = 0;
  int prev_range = 0;
  int prev_sweep = 0;
  int trig_run = 0;
  int acp_run = 0;
  int arp_run = 0;
  trig_exp_t e;

  always @(posedge clk) begin
    cyc++;
    if (reset) last_cyc = cyc;
  end

  always @(negedge clk) begin
    if (sweep_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sweep", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("gap", cyc - last_cyc, e.gap);
        chk("trig_with_sweep", int'(trig), 1);
        chk("acp", int'(acp), e.acp);
        chk("arp", int'(arp), e.arp);
        chk("azimuth", int'(azimuth), e.az);
        chk("range_at_trig", int'(range_cnt), 0);
        chk("range_before_trig", prev_range, e.rprev);
        chk("sweep_one_cycle", prev_sweep, 0);
      end
      last_cyc = cyc;
    end
    if (trig) trig_run++;
    else if (trig_run > 0) begin
      if (trig_w_q.size() == 0) chk("trig_w_unexpected", trig_w_q.size(), 1);
      else chk("trig_width", trig_run, trig_w_q.pop_front());
      trig_run = 0;
    end
    if (acp) acp_run++;
    else if (acp_run > 0) begin
      if (acp_w_q.size() == 0) chk("acp_w_unexpected", acp_w_q.size(), 1);
      else chk("acp_width", acp_run, acp_w_q.pop_front());
      acp_run = 0;
    end
    if (arp) arp_run++;
    else if (arp_run > 0) begin
      if (arp_w_q.size() == 0) chk("arp_w_unexpected", arp_w_q.size(), 1);
      else chk("arp_width", arp_run, arp_w_q.pop_front());
      arp_run = 0;
    end
    prev_range = int'(range_cnt);
    prev_sweep = int'(sweep_start);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk("reset_outputs", int'({trig, acp, arp, sweep_start, range_cnt, azimuth}), 0);
    end
    reset = 1'b0;
    en = 1'b1;
  endtask

  int az_a[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
  int gap_c[7] = '{1, 20, 25, 20, 25, 20, 20};

  initial begin
    // reset then run, ACP/ARP sequencing over 8 triggers, range saturation
    for (int k = 0; k < 8; k++)
      push_t((k == 0) ? 1 : 20, k % 2, (k == 7) ? 1 : 0, az_a[k], (k == 0) ? 0 : 15, 3, 2, 4);
    hold_reset(5);
    tick(1);
    chk("range_first_edge", int'(range_cnt), 0);
    chk("trig_first_edge", int'(trig), 1);
    tick(14);
    chk("range_14", int'(range_cnt), 14);
    tick(1);
    chk("range_15", int'(range_cnt), 15);
    tick(3);
    chk("range_sat_hold", int'(range_cnt), 15);
    tick(131);

    // stagger from reset, cleared partway through a 25-cycle PRI
    stagger = 1'b1;
    for (int k = 0; k < 7; k++)
      push_t(gap_c[k], k % 2, 0, az_a[k], (k == 0) ? 0 : 15, 3, 2, 4);
    hold_reset(3);
    tick(76);
    stagger = 1'b0;
    tick(65);

    // enable dropped in the second cycle of trig, held off for 10 cycles
    push_t(1, 0, 0, 0, 0, 2, 2, 4);
    push_t(30, 1, 0, 1, 15, 3, 2, 4);
    push_t(20, 0, 0, 1, 15, 3, 2, 4);
    hold_reset(3);
    tick(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("trig_gated", int'(trig), 0);
      chk("range_held", int'(range_cnt), 1);
    end
    en = 1'b1;
    tick(45);

    // reset mid-revolution while acp is high at azimuth 2, then rerun
    push_t(1, 0, 0, 0, 0, 3, 2, 4);
    push_t(20, 1, 0, 1, 15, 3, 2, 4);
    push_t(20, 0, 0, 1, 15, 3, 2, 4);
    push_t(20, 1, 0, 2, 15, 1, 1, 4);
    hold_reset(3);
    tick(61);
    chk("mid_acp_high", int'(acp), 1);
    chk("mid_azimuth", int'(azimuth), 2);
    reset = 1'b1;
    tick(1);
    chk("mid_reset_outputs", int'({trig, acp, arp, sweep_start, range_cnt, azimuth}), 0);
    push_t(1, 0, 0, 0, 0, 3, 2, 4);
    push_t(20, 1, 0, 1, 15, 3, 2, 4);
    push_t(20, 0, 0, 1, 15, 3, 2, 4);
    push_t(20, 1, 0, 2, 15, 3, 2, 4);
    hold_reset(4);
    tick(70);

    chk("triggers_missing", exp_q.size(), 0);
    chk("trig_widths_missing", trig_w_q.size(), 0);
    chk("acp_widths_missing", acp_w_q.size(), 0);
    chk("arp_widths_missing", arp_w_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radar_sync_gen.md
# radar_sync_gen

Parametrised radar timing generator for the sea-clutter board. It produces the trigger, ACP (azimuth change pulse) and ARP (azimuth reference pulse) strobes internally, replacing the externally supplied `trig_r`/`acp_r`/`arp_r` inputs when the board runs stand-alone. It also exposes a range-bin counter and an azimuth count for the clutter generator and the STC path. PRI, stagger, pulse widths and the azimuth resolution are all compile-time parameters.

## Interface
- `PRI_CYC`, 50000, base pulse repetition interval in clk cycles (1 ms at 50 MHz)
- `STAGGER_CYC`, 2500, extra cycles added to every second PRI in stagger mode
- `TRIG_W`, 50, trigger high width in cycles; 1 ≤ TRIG_W < PRI_CYC
- `TRIG_PER_ACP`, 4, triggers per ACP; ≥ 1
- `ACP_PER_ARP`, 4096, ACPs per antenna revolution; power of two, ≥ 2
- `ACP_W`, 25, ACP high width; 1 ≤ ACP_W ≤ PRI_CYC
- `ARP_W`, 25, ARP high width; 1 ≤ ARP_W ≤ PRI_CYC
- `RANGE_W`, 16, range counter width
- `AZ_W`, log2(ACP_PER_ARP), azimuth width (derived localparam)

- `clk` in 1, system clock
- `reset` in 1, synchronous, active-high
- `en` in 1, run enable
- `stagger` in 1, stagger mode select
- `trig` out 1, transmit trigger
- `acp` out 1, azimuth change pulse
- `arp` out 1, azimuth reference (north) pulse
- `sweep_start` out 1, one-cycle strobe coincident with the rising edge of `trig`
- `range_cnt` out RANGE_W, cycles since the last trigger, saturating
- `azimuth` out AZ_W, current ACP count within the revolution

## Operation
- PRI counter `pri_cnt` counts up from 0 to `pri_len`-1 and then wraps to 0. Each wrap to 0 is a trigger event.
- `pri_len` is latched at each trigger event. It equals `PRI_CYC` + (`stagger` && `tog` ? `STAGGER_CYC` : 0).
- `tog` inverts at every trigger event while `stagger`=1. It is forced to 0 whenever `stagger`=0.
- At a trigger event:
  - `trig` goes high for `TRIG_W` cycles.
  - `sweep_start` goes high for 1 cycle.
  - `range_cnt` loads 0.
- Outside trigger events, `range_cnt` increments by 1 per enabled cycle and saturates at 2^RANGE_W-1.
- Trigger index `tidx` counts 0..TRIG_PER_ACP-1.
- On the trigger event where `tidx`=TRIG_PER_ACP-1:
  - `acp` goes high for `ACP_W` cycles.
  - `azimuth` increments, modulo ACP_PER_ARP.
  - If `azimuth` wraps from ACP_PER_ARP-1 to 0, `arp` goes high for `ARP_W` cycles, starting in the same cycle as that `acp`.
- The first trigger after reset has `tidx`=0. So the first ACP is on trigger TRIG_PER_ACP-1 and the first ARP is on trigger TRIG_PER_ACP·ACP_PER_ARP-1.
- `en`=0:
  - `pri_cnt`, `tidx`, `azimuth`, `tog` and `range_cnt` hold their values.
  - `trig`, `acp`, `arp` and `sweep_start` are forced low, and their width counters clear. A pulse cut short by `en`=0 is not resumed.
  - When `en` returns to 1, counting resumes from the held `pri_cnt`.
- Reset overrides `en` and every other input.

## Timing
- All outputs are registered.
- Reset values: `trig`=`acp`=`arp`=`sweep_start`=0, `range_cnt`=0, `azimuth`=0. Internal state: `pri_cnt`=0, `tidx`=0, `tog`=0, `pri_len`=PRI_CYC.
- First trigger: in the first cycle with `reset`=0 and `en`=1, `pri_cnt`=0 is treated as a trigger event. `trig` and `sweep_start` are high from the following clock edge.
- Spacing: consecutive `trig` rising edges are exactly `pri_len` enabled cycles apart.
- Coincident pulses: `acp`, `arp`, `trig` and `sweep_start` rise on the same edge when they fall on the same trigger event. `azimuth` shows its new value on that same edge.
- Changing `stagger` affects only PRIs whose `pri_len` is latched after the change. A PRI already running keeps its length.
- Reset asserted mid-pulse or mid-revolution: all outputs are at their reset values one edge later.

## Test plan
Unless noted, all scenarios use PRI_CYC=20, STAGGER_CYC=5, TRIG_W=3, TRIG_PER_ACP=2, ACP_PER_ARP=4, ACP_W=2, ARP_W=4, RANGE_W=4.

- **Reset then run:** hold `reset` for 5 cycles, release with `en`=1, `stagger`=0.
  - All outputs are 0 during reset.
  - `trig` is high for exactly 3 cycles starting 1 edge after release. `sweep_start` is high 1 cycle.
  - Subsequent `trig` rising edges are 20 cycles apart.
- **ACP/ARP sequencing:** run 8 triggers.
  - `acp` (2 cycles wide) is high on triggers 1, 3, 5, 7.
  - `azimuth` reads 1, 2, 3, 0 at those triggers.
  - `arp` (4 cycles wide) is high only on trigger 7, coincident with `acp`.
- **Stagger:** set `stagger`=1 from reset; intervals between trigger edges are 20, 25, 20, 25. Clear `stagger` partway through a 25-cycle PRI; that PRI stays 25 and later ones are 20.
- **Range counter:** `range_cnt` is 0 on the `trig` rising edge, reaches 15 after 15 cycles, and holds 15 until the next trigger reloads 0.
- **Enable gating:** drop `en` during the second cycle of `trig`.
  - `trig` is low on the next edge and `pri_cnt`/`range_cnt` hold for 10 cycles.
  - After re-enable, the next trigger arrives `pri_len`-elapsed cycles later, and the interrupted pulse is not extended.
- **Reset mid-revolution:** assert `reset` at `azimuth`=2 while `acp` is high. All outputs are 0 on the next edge. After release, the sequence restarts exactly as in the "Reset then run" case.
